// File: rtl/game_pkg.sv
// Shared state codes and board constants for the tic-tac-toe flow controller.
package game_pkg;

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_PLAY  = 3'd1,
        ST_CHECK = 3'd2,
        ST_WIN_X = 3'd3,
        ST_WIN_O = 3'd4,
        ST_TIE   = 3'd5
    } state_t;

    localparam int unsigned NUM_LINES = 8;

    // Index 0..2 rows, 3..5 columns, 6..7 diagonals; bit i = cell i, row-major.
    localparam logic [NUM_LINES-1:0][8:0] WIN_LINES = {
        9'h054, 9'h111,
        9'h124, 9'h092, 9'h049,
        9'h1C0, 9'h038, 9'h007
    };

    localparam logic [8:0] FULL_BOARD = 9'h1FF;

endpackage

// File: rtl/win_detector.sv
// Flags whether a 9-cell occupancy matrix contains any complete line.
module win_detector
    import game_pkg::*;
(
    input  logic [8:0] matrix,
    output logic       win
);

    // A line is complete when every cell in its mask is occupied.
    always_comb begin
        win = 1'b0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            if (&(matrix | ~WIN_LINES[i])) begin
                win = 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// Match sequencer: click qualification, board ownership, turn tracking,
// win/tie detection, result-screen hold and score pulses.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned HOLD_W      = 26
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [8:0] clickedMatrix,
    input  logic       new_game,
    input  logic       clear_scores,
    output logic [8:0] x_matrix,
    output logic [8:0] o_matrix,
    output logic       turnoX,
    output logic       turnoO,
    output logic       ceStartScreen,
    output logic       cePlayingScreen,
    output logic       ceWinnerX,
    output logic       ceWinnerO,
    output logic       ceTie,
    output logic       inc_x_score,
    output logic       inc_o_score,
    output logic       resetScore,
    output logic [2:0] state
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_CYCLES);

    state_t            cur_st, nxt_st;
    logic [8:0]        click_prev;
    logic              click_pend, click_pend_nxt;
    logic [8:0]        cell_pend;
    logic              starter_x, starter_x_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [8:0]        x_nxt, o_nxt;
    logic              turn_x_nxt;
    logic              inc_x_nxt, inc_o_nxt;
    logic              ce_start_nxt, ce_play_nxt, ce_wx_nxt, ce_wo_nxt, ce_tie_nxt;
    logic              valid_click;
    logic              hold_done;
    logic              mover_win;
    logic [8:0]        mover_matrix;
    logic [8:0]        free_hit;

    assign valid_click  = $onehot(clickedMatrix) && (click_prev == '0);
    assign hold_done    = (hold_cnt >= HOLD_LIM);
    assign mover_matrix = turnoX ? x_matrix : o_matrix;
    assign free_hit     = cell_pend & ~(x_matrix | o_matrix);
    assign state        = cur_st;

    win_detector u_win_detector (
        .matrix (mover_matrix),
        .win    (mover_win)
    );

    // State, board and every output are registered here.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            cur_st          <= ST_START;
            click_prev      <= '0;
            click_pend      <= 1'b0;
            cell_pend       <= '0;
            starter_x       <= 1'b1;
            hold_cnt        <= '0;
            x_matrix        <= '0;
            o_matrix        <= '0;
            turnoX          <= 1'b1;
            turnoO          <= 1'b0;
            ceStartScreen   <= 1'b1;
            cePlayingScreen <= 1'b0;
            ceWinnerX       <= 1'b0;
            ceWinnerO       <= 1'b0;
            ceTie           <= 1'b0;
            inc_x_score     <= 1'b0;
            inc_o_score     <= 1'b0;
            resetScore      <= 1'b0;
        end else begin
            cur_st          <= nxt_st;
            click_prev      <= clickedMatrix;
            click_pend      <= click_pend_nxt;
            cell_pend       <= clickedMatrix;
            starter_x       <= starter_x_nxt;
            hold_cnt        <= hold_nxt;
            x_matrix        <= x_nxt;
            o_matrix        <= o_nxt;
            turnoX          <= turn_x_nxt;
            turnoO          <= ~turn_x_nxt;
            ceStartScreen   <= ce_start_nxt;
            cePlayingScreen <= ce_play_nxt;
            ceWinnerX       <= ce_wx_nxt;
            ceWinnerO       <= ce_wo_nxt;
            ceTie           <= ce_tie_nxt;
            inc_x_score     <= inc_x_nxt;
            inc_o_score     <= inc_o_nxt;
            resetScore      <= clear_scores;
        end
    end

    // Next-state and next-board logic; a qualified click is acted on one cycle after it is seen.
    always_comb begin
        nxt_st         = cur_st;
        x_nxt          = x_matrix;
        o_nxt          = o_matrix;
        turn_x_nxt     = turnoX;
        starter_x_nxt  = starter_x;
        hold_nxt       = '0;
        inc_x_nxt      = 1'b0;
        inc_o_nxt      = 1'b0;
        // new_game wins over a same-cycle click, and clicks seen during CHECK are discarded.
        click_pend_nxt = valid_click && !new_game && (cur_st != ST_CHECK);

        case (cur_st)
            ST_START: begin
                if (new_game || click_pend) begin
                    nxt_st     = ST_PLAY;
                    x_nxt      = '0;
                    o_nxt      = '0;
                    turn_x_nxt = starter_x;
                end
            end
            ST_PLAY: begin
                if (new_game) begin
                    x_nxt      = '0;
                    o_nxt      = '0;
                    turn_x_nxt = starter_x;
                end else if (click_pend && (free_hit != '0)) begin
                    if (turnoX) begin
                        x_nxt = x_matrix | cell_pend;
                    end else begin
                        o_nxt = o_matrix | cell_pend;
                    end
                    nxt_st = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (new_game) begin
                    nxt_st     = ST_PLAY;
                    x_nxt      = '0;
                    o_nxt      = '0;
                    turn_x_nxt = starter_x;
                end else if (mover_win) begin
                    nxt_st    = turnoX ? ST_WIN_X : ST_WIN_O;
                    inc_x_nxt = turnoX;
                    inc_o_nxt = ~turnoX;
                end else if ((x_matrix | o_matrix) == FULL_BOARD) begin
                    nxt_st = ST_TIE;
                end else begin
                    nxt_st     = ST_PLAY;
                    turn_x_nxt = ~turnoX;
                end
            end
            ST_WIN_X, ST_WIN_O, ST_TIE: begin
                if (!hold_done) begin
                    hold_nxt = hold_cnt + 1'b1;
                end else if (new_game || click_pend) begin
                    nxt_st        = ST_PLAY;
                    x_nxt         = '0;
                    o_nxt         = '0;
                    starter_x_nxt = ~starter_x;
                    turn_x_nxt    = ~starter_x;
                end else begin
                    hold_nxt = hold_cnt;
                end
            end
            default: begin
                nxt_st = ST_START;
            end
        endcase
    end

    // Screen enables are decoded from the next state so they register in step with it.
    always_comb begin
        ce_start_nxt = 1'b0;
        ce_play_nxt  = 1'b0;
        ce_wx_nxt    = 1'b0;
        ce_wo_nxt    = 1'b0;
        ce_tie_nxt   = 1'b0;
        case (nxt_st)
            ST_START:          ce_start_nxt = 1'b1;
            ST_PLAY, ST_CHECK: ce_play_nxt  = 1'b1;
            ST_WIN_X:          ce_wx_nxt    = 1'b1;
            ST_WIN_O:          ce_wo_nxt    = 1'b1;
            ST_TIE:            ce_tie_nxt   = 1'b1;
            default:           ce_start_nxt = 1'b1;
        endcase
    end

endmodule
